// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered decoder / scan sequencer.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    SCAN = 2'b10
  } state_t;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

endpackage

// File: rtl/decoder_onehot_therm.sv
// Combinational N-to-2^N decode: one-hot (bit[index]) or thermometer (bits[index:0]).
module decoder_onehot_therm #(
  parameter  int SEL_WIDTH = 4,
  localparam int OUT_WIDTH = 2**SEL_WIDTH
) (
  input  logic [SEL_WIDTH-1:0] index,
  input  logic                 therm,
  output logic [OUT_WIDTH-1:0] decoded
);

  // Each output bit compares its own position against the index.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (therm) decoded[i] = (SEL_WIDTH'(i) <= index);
      else       decoded[i] = (SEL_WIDTH'(i) == index);
    end
  end

endmodule

// File: rtl/decoder_sequencer.sv
// Registered decoder with load handshake, thermometer mode and dwell-timed scan.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | disabled or nothing loaded; outputs zero
//   HOLD  | last loaded (or last scanned) decode held on the outputs
//   SCAN  | stepping one-hot index from start to last, dwell+1 cycles each
module decoder_sequencer
  import decoder_pkg::*;
#(
  parameter  int SEL_WIDTH   = 4,
  parameter  int DWELL_WIDTH = 8,
  localparam int OUT_WIDTH   = 2**SEL_WIDTH
) (
  input  logic                   Clock_In,
  input  logic                   Reset_n_In,
  input  logic                   Enable_In,
  input  logic [1:0]             Mode_In,
  input  logic [SEL_WIDTH-1:0]   Encoded_Value_In,
  input  logic                   Load_Valid_In,
  output logic                   Load_Ready_Out,
  input  logic                   Scan_Start_In,
  input  logic [SEL_WIDTH-1:0]   Scan_Last_In,
  input  logic [DWELL_WIDTH-1:0] Scan_Dwell_In,
  output logic [OUT_WIDTH-1:0]   Decoded_Out,
  output logic [SEL_WIDTH-1:0]   Index_Out,
  output logic                   Valid_Out,
  output logic                   Scan_Busy_Out,
  output logic                   Scan_Done_Out
);

  state_t                 state_q, state_nxt;
  logic [SEL_WIDTH-1:0]   index_q, index_nxt;
  logic                   therm_q, therm_nxt;
  logic                   valid_q, valid_nxt;
  logic                   done_q, done_nxt;
  logic [SEL_WIDTH-1:0]   last_q, last_nxt;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_nxt;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [OUT_WIDTH-1:0]   decoded_q, dec_out;
  logic                   load_fire, scan_fire;

  assign Load_Ready_Out = Enable_In & (state_q != SCAN) & ~Mode_In[1];
  assign load_fire      = Load_Valid_In & Load_Ready_Out;
  assign scan_fire      = Scan_Start_In & Enable_In & (Mode_In == MODE_SCAN);

  // The decoder sees the next index so the output register updates in the same edge.
  decoder_onehot_therm #(.SEL_WIDTH(SEL_WIDTH)) u_decode (
    .index   (index_nxt),
    .therm   (therm_nxt),
    .decoded (dec_out)
  );

  // Next-state and next-register-value logic.
  always_comb begin
    state_nxt = state_q;
    index_nxt = index_q;
    therm_nxt = therm_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    last_nxt  = last_q;
    dwell_nxt = dwell_q;
    cnt_nxt   = cnt_q;
    if (!Enable_In) begin
      state_nxt = IDLE;
      index_nxt = '0;
      therm_nxt = 1'b0;
      valid_nxt = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (scan_fire) begin
            state_nxt = SCAN;
            index_nxt = Encoded_Value_In;
            therm_nxt = 1'b0;
            valid_nxt = 1'b1;
            last_nxt  = Scan_Last_In;
            dwell_nxt = Scan_Dwell_In;
            cnt_nxt   = Scan_Dwell_In;
          end else if (load_fire) begin
            state_nxt = HOLD;
            index_nxt = Encoded_Value_In;
            therm_nxt = Mode_In[0];
            valid_nxt = 1'b1;
          end
        end
        SCAN: begin
          if (cnt_q != '0) begin
            cnt_nxt = cnt_q - DWELL_WIDTH'(1);
          end else if (index_q == last_q) begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
          end else begin
            // Natural wrap of the index width gives modulo-OUT_WIDTH stepping.
            index_nxt = index_q + SEL_WIDTH'(1);
            cnt_nxt   = dwell_q;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, capture and output registers.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q   <= IDLE;
      index_q   <= '0;
      therm_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      decoded_q <= '0;
    end else begin
      state_q   <= state_nxt;
      index_q   <= index_nxt;
      therm_q   <= therm_nxt;
      valid_q   <= valid_nxt;
      done_q    <= done_nxt;
      last_q    <= last_nxt;
      dwell_q   <= dwell_nxt;
      cnt_q     <= cnt_nxt;
      decoded_q <= valid_nxt ? dec_out : '0;
    end
  end

  assign Decoded_Out   = decoded_q;
  assign Index_Out     = index_q;
  assign Valid_Out     = valid_q;
  assign Scan_Busy_Out = (state_q == SCAN);
  assign Scan_Done_Out = done_q;

endmodule

// File: doc/decoder_sequencer.md
# decoder_sequencer

Parametrised, registered N-to-2^N decoder that succeeds the fixed 4:16 combinational decoder. It adds a valid/ready load handshake, a thermometer decode mode, and an autonomous scan mode. The scan mode steps a one-hot output through a configurable index range with a programmable dwell. It drives row/channel-select and strobe fan-out in the data-selector family, where glitch-free registered outputs and timed sequencing are required.

## Interface
- SEL_WIDTH, 4, encoded index width (1..6)
- OUT_WIDTH, 2**SEL_WIDTH, decoded width; derived, not overridden
- DWELL_WIDTH, 8, dwell counter width
- Clock_In  input  1  single clock, rising edge
- Reset_n_In  input  1  asynchronous, active-low reset
- Enable_In  input  1  block enable; low forces IDLE
- Mode_In  input  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved (inert)
- Encoded_Value_In  input  SEL_WIDTH  load index / scan start index
- Load_Valid_In  input  1  load request
- Load_Ready_Out  output  1  load accept
- Scan_Start_In  input  1  scan start strobe
- Scan_Last_In  input  SEL_WIDTH  final scan index
- Scan_Dwell_In  input  DWELL_WIDTH  extra cycles held per index
- Decoded_Out  output  OUT_WIDTH  registered decode; bit 0 = LSB
- Index_Out  output  SEL_WIDTH  currently decoded index
- Valid_Out  output  1  Decoded_Out meaningful
- Scan_Busy_Out  output  1  scan in progress
- Scan_Done_Out  output  1  one-cycle scan-complete pulse

## Operation
- States: IDLE, HOLD, SCAN.
- Load_Ready_Out = Enable_In & (state != SCAN) & (Mode_In[1] == 0). It is combinational.
- Load handshake (Load_Valid_In & Load_Ready_Out) in IDLE/HOLD:
  - latch the index and the decode type (Mode_In[0]);
  - move to HOLD.
- Decode types:
  - one-hot: only bit[index] set;
  - thermometer: bits [index:0] set.
- HOLD: outputs held. Later Mode_In changes are ignored until the next load or scan.
- Scan start: Scan_Start_In & Enable_In & Mode_In == 10 in IDLE/HOLD.
  - Latch start = Encoded_Value_In, last = Scan_Last_In, dwell = Scan_Dwell_In.
  - Move to SCAN. Scan decode is always one-hot.
- SCAN:
  - each index is held dwell+1 cycles; dwell = 0 steps every cycle;
  - index increments modulo OUT_WIDTH, so last < start wraps through OUT_WIDTH-1 to 0;
  - start == last gives a single index.
- Scan end: when the dwell of the last index expires:
  - state moves to HOLD, still displaying the last index;
  - Scan_Done_Out pulses for 1 cycle;
  - Scan_Busy_Out drops.
- Scan_Start_In during SCAN is ignored. No restart.
- Enable_In low in any state: next cycle is IDLE, Decoded_Out = 0, Valid_Out = 0, Busy = 0, and no Done pulse (abort).
- Mode 11: no load accepted and scan start ignored. Current state and outputs are unaffected.
- Load_Valid_In with Mode_In == 10: not accepted (ready low). Only Scan_Start_In acts.
- Disabled outputs drive 0, never Z.

## Timing
- Reset (async assert, sync to clock on release): state IDLE; Decoded_Out, Index_Out, Valid_Out, Scan_Busy_Out, Scan_Done_Out all 0. Load_Ready_Out follows its equation.
- Load latency: handshake at edge t gives Decoded_Out/Index_Out/Valid_Out updated after edge t, visible in cycle t+1.
- Back-to-back loads are accepted every cycle in HOLD.
- Scan, with the start strobe sampled at edge t:
  - the start index is visible from cycle t+1, with Valid_Out = 1 and Scan_Busy_Out = 1;
  - with dwell D and K indices, the last index appears in cycle t+1+(K-1)(D+1);
  - Scan_Done_Out = 1 and Busy = 0 in cycle t+1+K(D+1).
- Reset asserted mid-scan: immediate return to reset values, no Done pulse.

## Structure
- Package decoder_pkg:
  - state enum (IDLE/HOLD/SCAN);
  - mode constants MODE_ONEHOT/MODE_THERM/MODE_SCAN/MODE_RSVD.
- Sub-module decoder_onehot_therm: purely combinational, parametrised on SEL_WIDTH. Inputs are index and type; output is OUT_WIDTH bits. Its output feeds the output register.
- Top level holds the FSM, index register, dwell counter, start/last/dwell capture registers and the output registers.
- Target 150–250 lines RTL total.

## Test plan
- Reset, then Enable=1, Mode=00, load 4'd5 → next cycle Decoded_Out = 16'h0020, Index_Out = 5, Valid_Out = 1.
- Mode=01, load 4'd3 → 16'h000F. Then change Mode to 00 without a load → output stays 16'h000F.
- Scan: Mode=10, start=14, last=1, dwell=2 → one-hot indices 14, 15, 0, 1, each held 3 cycles. Done pulses 13 cycles after start is sampled; Decoded_Out then holds 16'h0002.
- Scan with dwell=0, start=last=7 → 16'h0080 for 1 cycle, Done in the next cycle, Busy high exactly 1 cycle.
- Drop Enable mid-scan → next cycle all outputs 0, no Done. Assert Reset_n_In low mid-scan → outputs 0 asynchronously.
- Mode=11 or Mode=10 with Load_Valid_In=1 → Load_Ready_Out = 0 and outputs unchanged. Load_Valid_In + Scan_Start_In together with Mode=10 → only the scan starts.
